// File: rtl/ov7670_capture_if.sv
// Camera byte bus plus captured-pixel outputs of ov7670_capture.
// master = camera/consumer side, slave = capture block.
interface ov7670_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_d;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic [9:0]  x_cnt;
  logic [9:0]  y_cnt;
  logic        frame_start;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        line_err;
  logic [7:0]  err_cnt;

  modport master (
    output cam_vsync, cam_href, cam_d,
    input  pixel, pixel_valid, x_cnt, y_cnt, frame_start, frame_done,
           frame_cnt, line_err, err_cnt
  );

  modport slave (
    input  cam_vsync, cam_href, cam_d,
    output pixel, pixel_valid, x_cnt, y_cnt, frame_start, frame_done,
           frame_cnt, line_err, err_cnt
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-stream capture in the PCLK domain: pixels with x/y, frame markers.
// Define OV7670_CAP_ERR_EN to enable malformed line/frame detection (line_err, err_cnt).
module ov7670_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic config_done,
  ov7670_capture_if.slave bus
);

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE);

  typedef enum logic [1:0] {WAIT_CFG, WAIT_VS, WAIT_FRAME, CAPTURE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] cfg_sync_q;
  logic                   cfg_s;
  logic                   vs_q, hr_q, vs_prev_q, hr_prev_q;
  logic [7:0]             d_q, hi_q;
  logic                   phase_q;
  logic [9:0]             x_q, y_q;
  logic [15:0]            pixel_q;
  logic                   pixel_valid_q;
  logic [9:0]             x_cnt_q, y_cnt_q;
  logic                   frame_start_q, frame_done_q;
  logic [7:0]             frame_cnt_q;
  logic                   vs_rise, vs_fall, hr_fall;

  assign cfg_s   = cfg_sync_q[SYNC_STAGES-1];
  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_fall = ~hr_q & hr_prev_q;

`ifdef OV7670_CAP_ERR_EN
  logic       x_over_q, y_over_q;
  logic       line_err_q;
  logic [7:0] err_cnt_q;
  logic       line_bad, frame_bad;
  logic [9:0] lines_done;

  // Frame check sees the line count including a line that ends in the same cycle.
  always_comb begin
    line_bad   = (x_q != H_MAX) || x_over_q || phase_q;
    lines_done = (hr_fall && (y_q != V_MAX)) ? y_q + 10'd1 : y_q;
    frame_bad  = (lines_done != V_MAX) || y_over_q || (hr_fall && (y_q == V_MAX));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_CFG;
      cfg_sync_q    <= '0;
      vs_q          <= 1'b0;
      hr_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      hr_prev_q     <= 1'b0;
      d_q           <= '0;
      hi_q          <= '0;
      phase_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
`ifdef OV7670_CAP_ERR_EN
      x_over_q      <= 1'b0;
      y_over_q      <= 1'b0;
      line_err_q    <= 1'b0;
      err_cnt_q     <= '0;
`endif
    end else begin
      cfg_sync_q    <= {cfg_sync_q[SYNC_STAGES-2:0], config_done};
      vs_q          <= bus.cam_vsync;
      hr_q          <= bus.cam_href;
      d_q           <= bus.cam_d;
      vs_prev_q     <= vs_q;
      hr_prev_q     <= hr_q;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef OV7670_CAP_ERR_EN
      line_err_q    <= 1'b0;
`endif
      if (!cfg_s) begin
        state_q <= WAIT_CFG;
        phase_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_CFG: state_q <= WAIT_VS;
          WAIT_VS:  if (vs_rise) state_q <= WAIT_FRAME;
          WAIT_FRAME: begin
            if (vs_fall) begin
              state_q       <= CAPTURE;
              frame_start_q <= 1'b1;
              x_q           <= '0;
              y_q           <= '0;
              phase_q       <= 1'b0;
`ifdef OV7670_CAP_ERR_EN
              x_over_q      <= 1'b0;
              y_over_q      <= 1'b0;
`endif
            end
          end
          CAPTURE: begin
            // Line end is handled in the same cycle as a coinciding frame end.
            if (hr_fall) begin
              x_q     <= '0;
              phase_q <= 1'b0;
              if (y_q != V_MAX) y_q <= y_q + 10'd1;
`ifdef OV7670_CAP_ERR_EN
              else y_over_q <= 1'b1;
              x_over_q <= 1'b0;
`endif
            end else if (hr_q && !vs_rise) begin
              if (!phase_q) begin
                hi_q    <= d_q;
                phase_q <= 1'b1;
              end else begin
                phase_q       <= 1'b0;
                pixel_q       <= {hi_q, d_q};
                x_cnt_q       <= x_q;
                y_cnt_q       <= y_q;
                pixel_valid_q <= (x_q < H_MAX) && (y_q < V_MAX);
                if (x_q != H_MAX) x_q <= x_q + 10'd1;
`ifdef OV7670_CAP_ERR_EN
                else x_over_q <= 1'b1;
`endif
              end
            end
            if (vs_rise) begin
              state_q      <= WAIT_FRAME;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
`ifdef OV7670_CAP_ERR_EN
            if ((hr_fall && line_bad) || (vs_rise && frame_bad)) begin
              line_err_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
            end
`endif
          end
          default: state_q <= WAIT_CFG;
        endcase
      end
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.x_cnt       = x_cnt_q;
  assign bus.y_cnt       = y_cnt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;
`ifdef OV7670_CAP_ERR_EN
  assign bus.line_err    = line_err_q;
  assign bus.err_cnt     = err_cnt_q;
`else
  assign bus.line_err    = 1'b0;
  assign bus.err_cnt     = '0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized frame-level bench for ov7670_capture (H_ACTIVE=4, V_ACTIVE=2) against a
// scoreboard built from frame/line/byte descriptions.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic config_done;

  ov7670_capture_if bus_if ();

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .config_done (config_done),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pix;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   fs_obs, fd_obs, exp_fs, exp_fd, exp_fc, exp_err;
  int   last_x, last_y;
  bit   synced, cfg_ok;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_pixel"}, bus_if.pixel, 0);
    check_val({tag, "_pv"}, bus_if.pixel_valid, 0);
    check_val({tag, "_x"}, bus_if.x_cnt, 0);
    check_val({tag, "_y"}, bus_if.y_cnt, 0);
    check_val({tag, "_fs"}, bus_if.frame_start, 0);
    check_val({tag, "_fd"}, bus_if.frame_done, 0);
    check_val({tag, "_fcnt"}, bus_if.frame_cnt, 0);
    check_val({tag, "_lerr"}, bus_if.line_err, 0);
    check_val({tag, "_ecnt"}, bus_if.err_cnt, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_if.pixel_valid) begin
        check_val("pix_avail", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check_val("pixel", bus_if.pixel, e.pix);
          check_val("x_cnt", bus_if.x_cnt, e.x);
          check_val("y_cnt", bus_if.y_cnt, e.y);
        end
      end
      if (bus_if.frame_start) fs_obs++;
      if (bus_if.frame_done) begin
        fd_obs++;
        check_val("fd_exclusive", {bus_if.pixel_valid, bus_if.frame_start}, 0);
      end
    end
  end

  task automatic vs_rise_model(input bit cap, input int lines);
    if (cap) begin
      exp_fd++;
      exp_fc = (exp_fc + 1) % 256;
`ifdef OV7670_CAP_ERR_EN
      if (lines != V && exp_err < 255) exp_err++;
`endif
    end
    if (cfg_ok) synced = 1'b1;
  endtask

  // One frame: blanking, VSYNC fall, nl lines, VSYNC rise (or mid-line rise when ab).
  task automatic frame(input int nl, input int nb_fix, input bit ab, input bit cfg_mid,
                       input bit rst_mid);
    bit         cap, last_ab;
    int         nb, a, done_lines;
    logic [7:0] b [16];
    repeat (6) tick();
    bus_if.cam_vsync = 1'b0;
    cap = synced;
    if (cap) exp_fs++;
    repeat (4) tick();
    if (cfg_mid) begin
      config_done = 1'b1;
      cfg_ok      = 1'b1;
      repeat (4) tick();
    end
    done_lines = 0;
    for (int l = 0; l < nl; l++) begin
      last_ab = ab && (l == nl - 1);
      nb = (nb_fix != 0) ? nb_fix : int'($urandom_range(1, 12));
      if (last_ab) begin
        if (nb < 3) nb = 3;
        a = int'($urandom_range(1, nb - 1));
      end else a = nb;
      for (int j = 0; j < nb; j++)
        b[j] = (nb_fix != 0) ? ((j % 2 == 1) ? 8'hCD : 8'hAB) : 8'($urandom);
      if (cap) begin
        for (int k = 0; k < a / 2; k++) begin
          if (k < H && l < V)
            q.push_back('{pix: {b[2*k], b[2*k+1]}, x: 10'(k), y: 10'(l)});
          last_x = imin(k, H);
          last_y = imin(l, V);
        end
      end
      bus_if.cam_href = 1'b1;
      for (int j = 0; j < nb; j++) begin
        bus_if.cam_d = b[j];
        if (last_ab && j == a) begin
          bus_if.cam_vsync = 1'b1;
          vs_rise_model(cap, done_lines);
        end
        if (rst_mid && l == 0 && j == nb / 2) begin
          rst_n = 1'b0;
          q.delete();
          cap = 1'b0; synced = 1'b0;
          exp_fc = 0; exp_fs = 0; exp_fd = 0; exp_err = 0;
          fs_obs = 0; fd_obs = 0; last_x = 0; last_y = 0;
          tick();
          check_zero("rst_mid");
          rst_n = 1'b1;
        end
        tick();
      end
      bus_if.cam_href = 1'b0;
      bus_if.cam_d    = 8'h00;
      if (!last_ab && cap) begin
        done_lines++;
`ifdef OV7670_CAP_ERR_EN
        if (nb != 2 * H && exp_err < 255) exp_err++;
`endif
      end
      repeat (3) tick();
    end
    if (!ab) begin
      bus_if.cam_vsync = 1'b1;
      vs_rise_model(cap, done_lines);
    end
    repeat (8) tick();
    check_val("q_left", q.size(), 0);
    check_val("fs_cnt", fs_obs, exp_fs);
    check_val("fd_cnt", fd_obs, exp_fd);
    check_val("frame_cnt", bus_if.frame_cnt, exp_fc);
    check_val("x_hold", bus_if.x_cnt, last_x);
    check_val("y_hold", bus_if.y_cnt, last_y);
    check_val("err_cnt", bus_if.err_cnt, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; config_done = 1'b0;
    bus_if.cam_vsync = 1'b1; bus_if.cam_href = 1'b0; bus_if.cam_d = 8'h00;
    synced = 0; cfg_ok = 0; fs_obs = 0; fd_obs = 0;
    exp_fs = 0; exp_fd = 0; exp_fc = 0; exp_err = 0; last_x = 0; last_y = 0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) tick();

    frame(2, 8, 0, 0, 0);   // config low: ignored
    frame(2, 0, 0, 1, 0);   // config raised mid-frame: ignored
    frame(2, 8, 0, 0, 0);   // 4x2 frame of 0xABCD
    frame(2, 5, 0, 0, 0);   // odd byte count per line
    frame(1, 12, 0, 0, 0);  // overlong line, x holds at H
    frame(2, 0, 1, 0, 0);   // VSYNC rises during HREF
    frame(2, 0, 0, 0, 0);
    frame(2, 0, 0, 0, 1);   // reset mid-line
    frame(2, 8, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      frame(int'($urandom_range(1, 3)), 0, ($urandom_range(0, 3) == 0), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
